// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: captures a pattern on START and shifts it out MSB-first,
// optionally repeated with one-cycle gaps. Define SEQ_PATTERN_TX_PARITY_EN to append an odd-parity bit per copy.
module seq_pattern_tx #(
  parameter int   PAT_W      = 8,
  parameter int   CNT_W      = 4,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         START,
  input  logic [PAT_W-1:0]             PATTERN,
  input  logic [$clog2(PAT_W+1)-1:0]   LEN,
  input  logic [CNT_W-1:0]             REPEAT,
  output logic                         X,
  output logic                         VALID,
  output logic                         BUSY,
  output logic                         DONE
);

  localparam int LW = $clog2(PAT_W+1);
  localparam logic [LW-1:0] PAT_W_L = LW'(PAT_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
`ifdef SEQ_PATTERN_TX_PARITY_EN
    S_PAR,
`endif
    S_GAP,
    S_FIN
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [PAT_W-1:0] r_pat;
  logic [PAT_W-1:0] r_shift;
  logic [LW-1:0]    r_len;
  logic [LW-1:0]    r_idx;
  logic [CNT_W-1:0] r_rep;
`ifdef SEQ_PATTERN_TX_PARITY_EN
  logic             r_par;
`endif

  logic [LW-1:0]    w_len_eff;
  logic [LW-1:0]    w_shamt;
  logic [PAT_W-1:0] w_aligned;
  logic             w_load;
  logic             w_shift;
  logic             w_eoc;
  logic             w_reload;
  logic             w_x;
  logic             w_vld;
  logic             w_busy;
  logic             w_done;

  logic             r_x_p1;
  logic             r_vld_p1;
  logic             r_busy_p1;
  logic             r_done_p1;

  // Left-align the effective pattern so the first bit to send sits in the MSB.
  assign w_len_eff = (LEN == '0 || LEN > PAT_W_L) ? PAT_W_L : LEN;
  assign w_shamt   = PAT_W_L - w_len_eff;
  assign w_aligned = PATTERN << w_shamt;

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_x      = IDLE_LEVEL;
    w_vld    = 1'b0;
    w_busy   = 1'b0;
    w_done   = 1'b0;
    w_load   = 1'b0;
    w_shift  = 1'b0;
    w_eoc    = 1'b0;
    w_reload = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_load = 1'b1;
          w_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_x     = r_shift[PAT_W-1];
        w_vld   = 1'b1;
        w_busy  = 1'b1;
        w_shift = 1'b1;
        if (r_idx == '0) begin
`ifdef SEQ_PATTERN_TX_PARITY_EN
          w_next = S_PAR;
`else
          w_eoc  = 1'b1;
`endif
        end
      end
`ifdef SEQ_PATTERN_TX_PARITY_EN
      S_PAR: begin
        w_x    = ~r_par;
        w_vld  = 1'b1;
        w_busy = 1'b1;
        w_eoc  = 1'b1;
      end
`endif
      S_GAP: begin
        w_busy = 1'b1;
        w_next = S_SHIFT;
      end
      S_FIN: begin
        w_busy = 1'b1;
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_eoc) begin
      if (r_rep != '0) begin
        w_reload = 1'b1;
        w_next   = S_GAP;
      end else begin
        w_next   = S_FIN;
      end
    end
  end

  // Counters: the index stops at 0 and the copy counter only decrements when nonzero.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_idx <= '0;
      r_rep <= '0;
`ifdef SEQ_PATTERN_TX_PARITY_EN
      r_par <= 1'b0;
`endif
    end else if (w_load) begin
      r_idx <= w_len_eff - 1'b1;
      r_rep <= REPEAT;
`ifdef SEQ_PATTERN_TX_PARITY_EN
      r_par <= 1'b0;
`endif
    end else if (w_reload) begin
      r_idx <= r_len - 1'b1;
      r_rep <= r_rep - 1'b1;
`ifdef SEQ_PATTERN_TX_PARITY_EN
      r_par <= 1'b0;
`endif
    end else if (w_shift) begin
      if (r_idx != '0) r_idx <= r_idx - 1'b1;
`ifdef SEQ_PATTERN_TX_PARITY_EN
      r_par <= r_par ^ r_shift[PAT_W-1];
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (w_load) begin
      r_pat   <= w_aligned;
      r_shift <= w_aligned;
      r_len   <= w_len_eff;
    end else if (w_reload) begin
      r_shift <= r_pat;
    end else if (w_shift) begin
      r_shift <= r_shift << 1;
    end
  end

  // Output stage p1: registered copy of the decoded state outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_x_p1    <= IDLE_LEVEL;
      r_vld_p1  <= 1'b0;
      r_busy_p1 <= 1'b0;
      r_done_p1 <= 1'b0;
    end else begin
      r_x_p1    <= w_x;
      r_vld_p1  <= w_vld;
      r_busy_p1 <= w_busy;
      r_done_p1 <= w_done;
    end
  end

  assign X     = r_x_p1;
  assign VALID = r_vld_p1;
  assign BUSY  = r_busy_p1;
  assign DONE  = r_done_p1;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: directed and random transfers compared cycle by cycle
// against a per-copy bit-list model built from the transfer rules.
module tb_seq_pattern_tx;

  localparam logic IL = 1'b0;
`ifdef SEQ_PATTERN_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       CLK;
  logic       RESET;
  logic       START;
  logic [7:0] PATTERN;
  logic [3:0] LEN;
  logic [3:0] REPEAT;
  logic       X;
  logic       VALID;
  logic       BUSY;
  logic       DONE;

  int n_assert = 0;
  int n_fail   = 0;

  seq_pattern_tx #(.PAT_W(8), .CNT_W(4), .IDLE_LEVEL(IL)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .PATTERN(PATTERN),
    .LEN(LEN), .REPEAT(REPEAT), .X(X), .VALID(VALID), .BUSY(BUSY), .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input int idx, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {X, VALID, BUSY, DONE};
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d] x/valid/busy/done got %b expected %b", tag, idx, obs, exp);
    end
  endtask

  task automatic scramble();
    START   = 1'($urandom);
    PATTERN = 8'($urandom);
    LEN     = 4'($urandom);
    REPEAT  = 4'($urandom);
  endtask

  // Issues one transfer and checks every output cycle; hold keeps START high at the end.
  task automatic run(input string tag, input logic [7:0] pat, input logic [3:0] len,
                     input logic [3:0] rep, input bit hold);
    logic [3:0] q[$];
    int         L;
    logic       par;
    L = (len == 0 || len > 8) ? 8 : int'(len);
    for (int c = 0; c <= int'(rep); c++) begin
      par = 1'b1;
      for (int b = L - 1; b >= 0; b--) begin
        q.push_back({pat[b], 3'b110});
        par = par ^ pat[b];
      end
      if (PAR_EN) q.push_back({par, 3'b110});
      if (c < int'(rep)) q.push_back({IL, 3'b010});
    end
    q.push_back({IL, 3'b011});
    if (q.size() != (int'(rep) + 1) * (L + int'(PAR_EN)) + int'(rep) + 1)
      $fatal(1, "FAIL %s model length %0d", tag, q.size());

    RESET = 1'b0; START = 1'b1; PATTERN = pat; LEN = len; REPEAT = rep;
    tick();
    chk(tag, -1, {IL, 3'b000});
    scramble();
    for (int i = 0; i < q.size(); i++) begin
      tick();
      chk(tag, i, q[i]);
      if (i < q.size() - 1) scramble();
      else START = hold;
    end
    if (!hold) begin
      tick();
      chk(tag, q.size(), {IL, 3'b000});
    end
  endtask

  initial begin
    RESET = 1'b1; START = 1'b1; PATTERN = 8'h0B; LEN = 4'd4; REPEAT = 4'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_hold", i, {IL, 3'b000});
    end
    run("reset_release", 8'h0B, 4'd4, 4'd0, 1'b0);
    run("single_1011", 8'b0000_1011, 4'd4, 4'd0, 1'b0);
    run("repeat_gap", 8'b0000_0110, 4'd3, 4'd2, 1'b0);
    run("len0_a5", 8'hA5, 4'd0, 4'd0, 1'b0);
    run("len9_a5", 8'hA5, 4'd9, 4'd0, 1'b0);
    run("len1", 8'hFF, 4'd1, 4'd1, 1'b0);

    // Abort on the second bit, then confirm no DONE and a clean restart.
    START = 1'b1; PATTERN = 8'h0B; LEN = 4'd4; REPEAT = 4'd0;
    tick();
    chk("abort", 0, {IL, 3'b000});
    START = 1'b0;
    tick();
    chk("abort", 1, 4'b1110);
    tick();
    chk("abort", 2, 4'b0110);
    RESET = 1'b1;
    tick();
    chk("abort", 3, {IL, 3'b000});
    RESET = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_idle", i, {IL, 3'b000});
    end
    run("abort_restart", 8'h0B, 4'd4, 4'd0, 1'b0);

    run("hold_a", 8'h0B, 4'd4, 4'd1, 1'b1);
    run("hold_b", 8'h06, 4'd3, 4'd0, 1'b0);

    for (int t = 0; t < 20; t++)
      run("random", 8'($urandom), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern generator that drives a bit stream into the single-bit serial input of the lab's sequence-detector FSMs. A parallel pattern is captured on a start request, then shifted out MSB-first one bit per clock, optionally repeated with idle gaps between copies. It is the transmit end of the detector's serial interface: its `X` output connects directly to a detector's `X` input on the same `CLK`/`RESET`.

## Interface
- `PAT_W`, 8: maximum pattern length in bits.
- `CNT_W`, 4: width of the repeat counter.
- `IDLE_LEVEL`, 1'b0: value driven on `X` when no pattern bit is being sent.

- `CLK`  in  1  system clock; all state changes on the rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `START`  in  1  request to send; sampled only in IDLE.
- `PATTERN`  in  PAT_W  bits to send; bit `LEN-1` goes out first.
- `LEN`  in  $clog2(PAT_W+1)  number of bits per copy; 0 or values above PAT_W mean PAT_W.
- `REPEAT`  in  CNT_W  number of additional copies (0 means send once).
- `X`  out  1  serial data, registered.
- `VALID`  out  1  high while `X` carries a pattern bit (or parity bit), registered.
- `BUSY`  out  1  high from the cycle after START is accepted until the cycle DONE is asserted, inclusive.
- `DONE`  out  1  single-cycle pulse after the last bit of the last copy.

## Operation
- States: IDLE, SHIFT, PAR (only with the macro), GAP, FIN.
- IDLE:
  - `X`=IDLE_LEVEL, `VALID`=0, `BUSY`=0.
  - On `START`=1: latch `PATTERN`, the effective `LEN` and `REPEAT` into internal registers, load the bit index with LEN-1 and the copy counter with REPEAT, then go to SHIFT.
- SHIFT:
  - Each cycle drive `X`=latched_pattern[index] with `VALID`=1.
  - When index reaches 0, go to PAR if the macro is enabled; otherwise go to the end-of-copy decision.
- End-of-copy decision:
  - If the copy counter is nonzero, decrement it, reload index to LEN-1 and go to GAP.
  - Otherwise go to FIN.
- GAP: exactly one cycle with `X`=IDLE_LEVEL and `VALID`=0, then SHIFT.
- FIN: `DONE`=1 and `BUSY`=1 for one cycle with `X`=IDLE_LEVEL, then IDLE.
- Input changes after the start request is accepted have no effect on the transfer in progress.
- `START` is ignored in any state other than IDLE. It is level-sampled, so if `START` is still high in IDLE after FIN, a new transfer begins.
- Arithmetic: index and copy counter are unsigned; neither wraps. The copy counter saturates at 0 and the terminal decision uses `==0`.

## Timing
- Reset values: `X`=IDLE_LEVEL, `VALID`=0, `BUSY`=0, `DONE`=0, state=IDLE, all counters 0.
- Let `START` be sampled high at edge k:
  - First pattern bit appears on `X` after edge k+1, so the latency is 1 cycle.
  - One copy occupies LEN cycles, plus 1 cycle when parity is enabled.
  - Total cycles from k+1 to the `DONE` cycle inclusive = (REPEAT+1)·(LEN+P) + REPEAT + 1, where P is 1 with the macro and 0 without.
- `RESET` during any state: on that edge, all outputs return to their reset values and state goes to IDLE. No `DONE` is issued for an aborted transfer.
- `RESET` and `START` high on the same edge: reset wins and the transfer does not start.

## Configuration
- `SEQ_PATTERN_TX_PARITY_EN` defined:
  - After the last pattern bit of each copy, one PAR cycle drives `X` = odd parity over the LEN sent bits (XOR of the bits, inverted) with `VALID`=1.
  - The parity bit is computed while shifting, not from the full `PATTERN` bus.
- Not defined: the PAR state and parity logic are absent, and copies are exactly LEN bits.

## Test plan
- Reset check: hold `RESET` 3 cycles with `START`=1 -> `X`=0, `VALID`/`BUSY`/`DONE`=0 throughout. Release `RESET` -> first bit appears 1 cycle later.
- Single copy, no macro: PATTERN=8'b0000_1011, LEN=4, REPEAT=0 -> `X`=1,0,1,1 with `VALID`=1 for 4 cycles. `DONE` is high on the 5th cycle, `BUSY` high for cycles 1-5.
- Repeat with gap: PATTERN=8'b0000_0110, LEN=3, REPEAT=2 -> `X` sequence 1,1,0,g,1,1,0,g,1,1,0 (g = IDLE_LEVEL, `VALID`=0), then `DONE`. Total 12 cycles.
- Edge cases: LEN=0 and LEN=9 with PATTERN=8'hA5 -> 8 bits 1,0,1,0,0,1,0,1 in both cases. Toggling `START` and `PATTERN` mid-transfer has no effect.
- Abort: assert `RESET` on the 2nd bit of a 4-bit transfer -> `X`=0 and `VALID`=0 next cycle, no `DONE`. A fresh `START` afterwards sends the full pattern.
- Macro build: PATTERN=4'b1011, LEN=4 -> `X`=1,0,1,1,0 (parity bit 0), then `DONE`. Loopback into a detector for 1011 produces the expected detector output pulse.
